// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, major opcodes, the canonical NOP
// and the fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] BRANCH_OP    = 7'b1100011;
    localparam logic [6:0] LOAD_OP      = 7'b0000011;
    localparam logic [6:0] STORE_OP     = 7'b0100011;
    localparam logic [6:0] IMM_ARITH_OP = 7'b0010011;
    localparam logic [6:0] ARITH_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Program counter register with next-PC selection: sequential pc+4 or an aligned
// branch target, advanced only when the held instruction is consumed.
module pc_gen #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            consume,
    input  logic            branch_ctrl,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] seqPc;
    logic [XLEN-1:0] alignedTarget;
    logic [XLEN-1:0] pcNext;

    always_comb begin
        seqPc         = pc + XLEN'(4);
        // Low two bits cleared so the PC can never become misaligned.
        alignedTarget = branch_target & ~XLEN'(3);
        pcNext        = (branch_ctrl && branch_taken) ? alignedTarget : seqPc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (consume) begin
            pc <= pcNext;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one imem request at a time, holds the returned
// instruction for the control unit and steps the PC when it is consumed.
module fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            branch_ctrl,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc
);

    import riscv_pkg::*;

    fetch_state_t state;
    fetch_state_t nextState;
    logic         captureRsp;
    logic         consume;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        captureRsp = 1'b0;
        consume    = 1'b0;
        case (state)
            REQ: begin
                if (imem_req_ready) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    captureRsp = 1'b1;
                    nextState  = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    consume   = 1'b1;
                    nextState = REQ;
                end
            end
            default: nextState = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (captureRsp) begin
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
        end else if (consume) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end
    end

    pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) pcGen (
        .clk           (clk),
        .rst           (rst),
        .consume       (consume),
        .branch_ctrl   (branch_ctrl),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc)
    );

    assign imem_req_valid = (state == REQ) && !rst;
    assign imem_req_addr  = pc;
    assign opcode         = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences, then random stimulus against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_W = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst, ready, rspValid, bc, bt, stall;
    logic [31:0] rspData, tgt;

    logic        reqValid, instrValid, reqValidW, instrValidW;
    logic [31:0] reqAddr, instr, pc, reqAddrW, instrW, pcW;
    logic [6:0]  opcode, opcodeW;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (reqValid),
        .imem_req_ready (ready),
        .imem_req_addr  (reqAddr),
        .imem_rsp_valid (rspValid),
        .imem_rsp_data  (rspData),
        .branch_ctrl    (bc),
        .branch_taken   (bt),
        .branch_target  (tgt),
        .stall          (stall),
        .instr_valid    (instrValid),
        .instr          (instr),
        .opcode         (opcode),
        .pc             (pc)
    );

    fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC_W),
        .NOP_INSTR (NOP)
    ) dutW (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (reqValidW),
        .imem_req_ready (ready),
        .imem_req_addr  (reqAddrW),
        .imem_rsp_valid (rspValid),
        .imem_rsp_data  (rspData),
        .branch_ctrl    (bc),
        .branch_taken   (bt),
        .branch_target  (tgt),
        .stall          (stall),
        .instr_valid    (instrValidW),
        .instr          (instrW),
        .opcode         (opcodeW),
        .pc             (pcW)
    );

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] data;
        logic        bc, bt;
        logic [31:0] tgt;
        logic        stall;
        logic        eReqV;
        logic [31:0] eAddr;
        logic        eIv;
        logic [31:0] eInstr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic rd, logic v, logic [31:0] d, logic c, logic t,
                                logic [31:0] g, logic s, logic erv, logic [31:0] ea,
                                logic eiv, logic [31:0] ei);
        vec_t x;
        x.rst = r; x.rdy = rd; x.rv = v; x.data = d; x.bc = c; x.bt = t; x.tgt = g; x.stall = s;
        x.eReqV = erv; x.eAddr = ea; x.eIv = eiv; x.eInstr = ei;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic setIn(input logic r, input logic rd, input logic v, input logic [31:0] d,
                         input logic c, input logic t, input logic [31:0] g, input logic s);
        rst = r; ready = rd; rspValid = v; rspData = d; bc = c; bt = t; tgt = g; stall = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkMain(input string tag, input logic erv, input logic [31:0] ea,
                             input logic eiv, input logic [31:0] ei);
        logic [31:0] eiCopy;
        eiCopy = ei;
        check({tag, ".req_valid"}, {31'b0, reqValid}, {31'b0, erv});
        check({tag, ".req_addr"}, reqAddr, ea);
        check({tag, ".pc"}, pc, ea);
        check({tag, ".instr_valid"}, {31'b0, instrValid}, {31'b0, eiv});
        check({tag, ".instr"}, instr, ei);
        check({tag, ".opcode"}, {25'b0, opcode}, {25'b0, eiCopy[6:0]});
    endtask

    // Reference model state: a request is outstanding, an instruction is held.
    logic        mBusy, mHave;
    logic [31:0] mPc, mPcW, mInstr;

    initial begin
        setIn(1, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Directed table: reset, three sequential fetches, branch outcomes.
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,32'h00,0,NOP));
        vecs.push_back(mk(1,1,0,0,0,0,0,0, 0,32'h00,0,NOP));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h00,0,NOP));
        vecs.push_back(mk(0,1,1,32'h00500093,0,0,0,0, 0,32'h00,0,NOP));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,32'h00,1,32'h00500093));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h04,0,NOP));
        vecs.push_back(mk(0,1,1,32'h00A00113,0,0,0,0, 0,32'h04,0,NOP));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,32'h04,1,32'h00A00113));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h08,0,NOP));
        vecs.push_back(mk(0,1,1,32'h002081B3,0,0,0,0, 0,32'h08,0,NOP));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,32'h08,1,32'h002081B3));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h0C,0,NOP));
        vecs.push_back(mk(0,1,1,32'h00308213,0,0,0,0, 0,32'h0C,0,NOP));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 0,32'h0C,1,32'h00308213));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h10,0,NOP));
        vecs.push_back(mk(0,1,1,32'h00208463,0,0,0,0, 0,32'h10,0,NOP));
        vecs.push_back(mk(0,1,0,0,1,0,32'h42,0, 0,32'h10,1,32'h00208463));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h14,0,NOP));
        vecs.push_back(mk(0,1,1,32'h00208463,0,0,0,0, 0,32'h14,0,NOP));
        vecs.push_back(mk(0,1,0,0,1,1,32'h42,0, 0,32'h14,1,32'h00208463));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h40,0,NOP));
        vecs.push_back(mk(0,1,1,32'h00208463,0,0,0,0, 0,32'h40,0,NOP));
        vecs.push_back(mk(0,1,0,0,0,1,32'h103,0, 0,32'h40,1,32'h00208463));
        vecs.push_back(mk(0,1,0,0,0,0,0,0, 1,32'h44,0,NOP));

        foreach (vecs[i]) begin
            setIn(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].data,
                  vecs[i].bc, vecs[i].bt, vecs[i].tgt, vecs[i].stall);
            checkMain($sformatf("vec%0d", i), vecs[i].eReqV, vecs[i].eAddr,
                      vecs[i].eIv, vecs[i].eInstr);
            tick();
        end

        // Reset from WAIT, then request held off by ready=0 with spurious responses.
        setIn(1, 0, 0, 0, 0, 0, 0, 0);
        check("rst_in_wait.req_valid", {31'b0, reqValid}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            setIn(0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
            checkMain($sformatf("req_hold%0d", i), 1, 32'h0, 0, NOP);
            check("wrap.reset_addr", reqAddrW, RESET_PC_W);
            tick();
        end
        setIn(0, 1, 0, 0, 0, 0, 0, 0);
        checkMain("req_accept", 1, 32'h0, 0, NOP);
        tick();
        for (int i = 0; i < 2; i++) begin
            setIn(0, 0, 0, 0, 0, 0, 0, 0);
            checkMain($sformatf("wait%0d", i), 0, 32'h0, 0, NOP);
            tick();
        end
        setIn(0, 0, 1, 32'h40000033, 0, 0, 0, 0);
        checkMain("rsp", 0, 32'h0, 0, NOP);
        tick();

        // Stall in HOLD: everything frozen, no request, late responses ignored.
        for (int i = 0; i < 4; i++) begin
            setIn(0, 1, 1, 32'hFFFFFFFF, 1, 1, 32'h80, 1);
            checkMain($sformatf("stall%0d", i), 0, 32'h0, 1, 32'h40000033);
            tick();
        end
        setIn(0, 1, 0, 0, 0, 0, 0, 0);
        checkMain("unstall", 0, 32'h0, 1, 32'h40000033);
        tick();
        setIn(0, 1, 0, 0, 0, 0, 0, 0);
        checkMain("after_stall_req", 1, 32'h4, 0, NOP);
        check("wrap.pc_plus4", reqAddrW, 32'h0000_0000);
        tick();

        // Reset asserted while waiting on a response.
        setIn(1, 0, 0, 0, 0, 0, 0, 0);
        checkMain("rst_wait", 0, 32'h4, 0, NOP);
        tick();
        setIn(0, 0, 0, 0, 0, 0, 0, 0);
        checkMain("post_rst", 1, 32'h0, 0, NOP);
        check("wrap.post_rst_addr", reqAddrW, RESET_PC_W);
        tick();

        // Random stimulus against the reference model (DUT is in REQ, pc=RESET_PC).
        mBusy = 0; mHave = 0; mPc = 0; mPcW = RESET_PC_W; mInstr = NOP;
        for (int n = 0; n < 800; n++) begin
            logic r, rd, v, c, t, s;
            logic [31:0] d, g;
            r  = ($urandom_range(39) == 0);
            rd = ($urandom_range(9) < 6);
            v  = ($urandom_range(1) == 1);
            d  = $urandom;
            c  = ($urandom_range(1) == 1);
            t  = ($urandom_range(1) == 1);
            g  = $urandom;
            s  = ($urandom_range(9) < 3);
            setIn(r, rd, v, d, c, t, g, s);
            checkMain($sformatf("rnd%0d", n), !r && !mBusy && !mHave, mPc, mHave, mInstr);
            check($sformatf("rnd%0d.wrap_addr", n), reqAddrW, mPcW);

            if (r) begin
                mBusy = 0; mHave = 0; mPc = 0; mPcW = RESET_PC_W; mInstr = NOP;
            end else if (mHave) begin
                if (!s) begin
                    if (c && t) begin
                        mPc  = {g[31:2], 2'b00};
                        mPcW = {g[31:2], 2'b00};
                    end else begin
                        mPc  = mPc + 32'd4;
                        mPcW = mPcW + 32'd4;
                    end
                    mHave  = 0;
                    mInstr = NOP;
                end
            end else if (mBusy) begin
                if (v) begin
                    mInstr = d;
                    mHave  = 1;
                    mBusy  = 0;
                end
            end else if (rd) begin
                mBusy = 1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the control unit in the single-cycle RISC-V core. Owns the PC and issues one request at a time to instruction memory over a valid/ready request and valid response interface. Holds the returned instruction and presents it, with its opcode field, to the control unit. Selects the next PC from the branch decision fed back by the control unit and ALU.

Parameters:
XLEN, 32, PC and address width
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned
NOP_INSTR, 32'h0000_0013, instruction driven while no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  response data valid
imem_rsp_data  in  32  fetched instruction word
branch_ctrl  in  1  from control unit: held instruction is a branch
branch_taken  in  1  from ALU: branch condition true
branch_target  in  XLEN  computed branch target
stall  in  1  downstream cannot consume the held instruction this cycle
instr_valid  out  1  instr/opcode/pc hold a fetched instruction
instr  out  32  held instruction
opcode  out  7  instr[6:0], feeds control unit opcode input
pc  out  XLEN  address of held instruction

Behaviour:
- One clock; reset is synchronous and active-high on rst. All registers update on the rising edge of clk.
- Reset values: state=REQ, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0.
- imem_req_valid=0 while rst=1. Outside reset, imem_req_valid=1 exactly when state=REQ. imem_req_addr=pc at all times.
- FSM states:
  - REQ: drive the request. If imem_req_ready=1, go to WAIT. Otherwise stay in REQ; addr and valid stay stable.
  - WAIT: on imem_rsp_valid=1, set instr<=imem_rsp_data and instr_valid<=1, then go to HOLD. Otherwise stay in WAIT.
  - HOLD: instr, opcode and pc stay stable while stall=1. When stall=0, the instruction is consumed:
    - pc <= (branch_ctrl & branch_taken) ? {branch_target[XLEN-1:2],2'b00} : pc+4;
    - instr_valid<=0, instr<=NOP_INSTR, go to REQ.
- imem_rsp_valid in REQ or HOLD is ignored. Only one request is outstanding at a time.
- Responses arrive no earlier than the cycle after the request handshake.
- Best-case latency: handshake in cycle 0, response in cycle 1, instr_valid=1 in cycle 2, next request in cycle 3. Throughput is one instruction per 3 cycles.
- pc+4 wraps modulo 2^XLEN.
- branch_target bits [1:0] are forced to 0.
- branch_ctrl and branch_taken are sampled only in HOLD with stall=0; otherwise they are don't-care.
- Reset mid-operation: in any state, the next cycle is REQ with pc=RESET_PC. Instruction memory shares rst, so no stale response survives reset.
- opcode is a combinational slice of the instr register.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN;
  - opcode constants BRANCH_OP 7'b1100011, LOAD_OP 7'b0000011, STORE_OP 7'b0100011, IMM_ARITH_OP 7'b0010011, ARITH_OP 7'b0110011;
  - NOP_INSTR;
  - enum fetch_state_t {REQ, WAIT, HOLD}.
- One sub-module, pc_gen: PC register plus next-PC mux (inputs consume, branch_ctrl, branch_taken, branch_target).

Test Plan:
1. Assert rst 2 cycles -> imem_req_valid=0, imem_req_addr=0x0, instr_valid=0, instr=0x00000013. Release rst -> imem_req_valid=1 in the first cycle.
2. Ready always 1, response 1 cycle later returning 0x00500093, 0x00A00113, 0x002081B3, stall=0 -> request addresses 0x0, 0x4, 0x8. instr_valid pulses 1 cycle every 3 cycles. opcode sequence 0x13, 0x13, 0x33.
3. At pc=0x10 return 0x00208463 (branch). Drive branch_ctrl=1, branch_taken=1, branch_target=0x42 -> next request addr=0x40. Repeat with branch_taken=0 -> next addr=0x14.
4. imem_req_ready=0 for 5 cycles in REQ -> imem_req_valid=1 and addr stable all 5 cycles. Spurious imem_rsp_valid in REQ is ignored and instr stays NOP.
5. stall=1 for 4 cycles in HOLD -> instr, pc, instr_valid stable and no request issued. Request issued the cycle after stall drops.
6. RESET_PC=0xFFFFFFFC, consume with no branch -> next addr=0x00000000. Assert rst during WAIT -> next cycle REQ with pc=RESET_PC and instr_valid=0.
